// File: rtl/pim_host_sequencer_if.sv
// Command, payload, result and peripheral-port signals of the PIM host sequencer.
// Signal names carry the direction as seen from the sequencer (slave modport).
interface pim_host_sequencer_if;
    // Command channel
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [2:0]  cmd_mode_i;
    logic [6:0]  cmd_row_i;
    logic [8:0]  cmd_col_i;
    logic [3:0]  cmd_len_i;
    logic [31:0] cmd_zp_i;
    // LOAD_IN payload stream
    logic        wdata_valid_i;
    logic [31:0] wdata_i;
    logic        wdata_ready_o;
    // READ_OUT result stream
    logic        rdata_valid_o;
    logic [31:0] rdata_o;
    logic        rdata_ready_i;
    // Peripheral register port
    logic [31:0] peri_addr_o;
    logic [31:0] peri_data_o;
    logic [31:0] peri_data_i;
    // Status
    logic        busy_o;
    logic        done_o;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_mode_i, cmd_row_i, cmd_col_i, cmd_len_i, cmd_zp_i,
        input  wdata_valid_i, wdata_i, rdata_ready_i, peri_data_i,
        output cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
        output peri_addr_o, peri_data_o, busy_o, done_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_mode_i, cmd_row_i, cmd_col_i, cmd_len_i, cmd_zp_i,
        output wdata_valid_i, wdata_i, rdata_ready_i, peri_data_i,
        input  cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
        input  peri_addr_o, peri_data_o, busy_o, done_o
    );
endinterface

// File: rtl/pim_host_sequencer.sv
// PIM host sequencer: turns one high-level command (LOAD_IN, SET_ZP, EXEC, READ_OUT)
// into single-cycle address/data transactions on the peripheral register port.
//
// Handshakes (cmd, wdata, rdata): a transfer happens on the rising clock edge where
// valid and ready are both high; the producer keeps valid and its payload stable until
// that edge, and ready never depends on anything but the sequencer state.
module pim_host_sequencer #(
    parameter logic [31:0] ADDR_INBUF  = 32'h0000_1000,
    parameter logic [31:0] ADDR_ZP     = 32'h0000_1004,
    parameter logic [31:0] ADDR_EXEC   = 32'h0000_1008,
    parameter logic [31:0] ADDR_OUTBUF = 32'h0000_100C,
    parameter int unsigned READ_LAT    = 2,
    parameter int unsigned EXEC_WAIT   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    pim_host_sequencer_if.slave bus,
    output logic [3:0]          dbg_state_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_ZP, S_EXEC, S_EWAIT, S_RD_ISSUE, S_RD_WAIT, S_RD_HOLD, S_DONE
    } state_e;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_ZP   = 2'd1;
    localparam logic [1:0] OP_EXEC = 2'd2;

    // One timer serves both the post-execute wait and the read latency.
    localparam int unsigned TMR_MAX = (EXEC_WAIT > READ_LAT) ? EXEC_WAIT : READ_LAT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] EWAIT_LAST = TMR_W'((EXEC_WAIT > 0) ? EXEC_WAIT - 1 : 0);
    localparam logic [TMR_W-1:0] RD_LAST    = TMR_W'(READ_LAT - 1);

    state_e           state_q, state_d;
    logic [3:0]       len_q, len_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [31:0]      zp_q, zp_d;
    logic [31:0]      exec_q, exec_d;
    logic [31:0]      rdata_q, rdata_d;

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            zp_q    <= '0;
            exec_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            zp_q    <= zp_d;
            exec_q  <= exec_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and output decode; every peripheral access lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        zp_d    = zp_q;
        exec_d  = exec_q;
        rdata_d = rdata_q;

        // Gated with reset so every output reads 0 while reset is held.
        bus.cmd_ready_o   = (state_q == S_IDLE) && rst_ni;
        bus.wdata_ready_o = 1'b0;
        bus.rdata_valid_o = 1'b0;
        bus.rdata_o       = rdata_q;
        bus.peri_addr_o   = '0;
        bus.peri_data_o   = '0;
        bus.busy_o        = (state_q != S_IDLE);
        bus.done_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    len_d  = bus.cmd_len_i;
                    zp_d   = bus.cmd_zp_i;
                    // Execute word: mode[18:16], row[15:9], col[8:0].
                    exec_d = {13'b0, bus.cmd_mode_i, bus.cmd_row_i, bus.cmd_col_i};
                    cnt_d  = '0;
                    tmr_d  = '0;
                    case (bus.cmd_op_i)
                        OP_LOAD: state_d = S_LOAD;
                        OP_ZP:   state_d = S_ZP;
                        OP_EXEC: state_d = S_EXEC;
                        default: state_d = S_RD_ISSUE;
                    endcase
                end
            end
            S_LOAD: begin
                bus.wdata_ready_o = 1'b1;
                if (bus.wdata_valid_i) begin
                    bus.peri_addr_o = ADDR_INBUF;
                    bus.peri_data_o = bus.wdata_i;
                    if (cnt_q == len_q) state_d = S_DONE;
                    else                cnt_d   = cnt_q + 4'd1;
                end
            end
            S_ZP: begin
                bus.peri_addr_o = ADDR_ZP;
                bus.peri_data_o = zp_q;
                state_d         = S_DONE;
            end
            S_EXEC: begin
                bus.peri_addr_o = ADDR_EXEC;
                bus.peri_data_o = exec_q;
                tmr_d           = '0;
                state_d         = (EXEC_WAIT == 0) ? S_DONE : S_EWAIT;
            end
            S_EWAIT: begin
                if (tmr_q == EWAIT_LAST) state_d = S_DONE;
                else                     tmr_d   = tmr_q + 1'b1;
            end
            S_RD_ISSUE: begin
                bus.peri_addr_o = ADDR_OUTBUF;
                tmr_d           = '0;
                state_d         = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // Read data is valid exactly READ_LAT cycles after the issue cycle.
                if (tmr_q == RD_LAST) begin
                    rdata_d = bus.peri_data_i;
                    state_d = S_RD_HOLD;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RD_HOLD: begin
                bus.rdata_valid_o = 1'b1;
                if (bus.rdata_ready_i) begin
                    if (cnt_q == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_DONE: begin
                bus.done_o = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dbg_state_o = state_q;

endmodule
